// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer with three phases.
//   FETCH: request the word at pc and wait for memory (any number of cycles).
//   EXEC : present the instruction to the decoder. The word is retired once
//          stall is low, and the next pc then comes from pc_control.
//   HALT : terminal state. All registers are frozen and only reset leaves it.
// Ports:
//   clk, reset        - single clock; synchronous active-high reset
//   pc_control[2:0]   - next-pc select: 000 seq, 001 jump, 011 branch, 111 halt
//   stall             - decoder not ready; hold the current instruction
//   imem_req/addr     - read request and word-aligned address
//   imem_ready/rdata  - read data returned (ready may arrive with req)
//   instruction       - latched instruction word
//   instr_valid       - instruction valid; pc_control sampled this cycle
//   pc                - address of the held instruction
//   halted            - sticky halt flag
//   instr_count       - retired instruction count (halt included), wraps
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  pc_control,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic        halted,
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        PC_SEQ    = 3'b000,
        PC_JUMP   = 3'b001,
        PC_BRANCH = 3'b011,
        PC_HALT   = 3'b111
    } pc_sel_t;

    state_t      state, state_next;
    logic [31:0] pc_next;
    logic [31:0] instr_next;
    logic [31:0] count_next;
    logic        halted_next;
    logic        fetch_phase;

    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] branch_target;

    assign pc_plus4      = pc + 32'd4;
    assign jump_target   = {pc_plus4[31:28], instruction[25:0], 2'b00};
    assign branch_target = pc_plus4 + {{14{instruction[15]}}, instruction[15:0], 2'b00};

    // Request is combinational so that a zero-wait memory can answer in the
    // same cycle. It is masked while reset is held, so a fetch that is in
    // flight when reset arrives is dropped.
    assign imem_req  = fetch_phase && !reset;
    assign imem_addr = {pc[31:2], 2'b00};

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        instr_next  = instruction;
        count_next  = instr_count;
        halted_next = halted;
        fetch_phase = 1'b0;
        instr_valid = 1'b0;

        case (state)
            FETCH: begin
                fetch_phase = 1'b1;
                if (imem_ready) begin
                    instr_next = imem_rdata;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    count_next = instr_count + 32'd1;
                    case (pc_sel_t'(pc_control))
                        PC_JUMP: begin
                            pc_next    = jump_target;
                            state_next = FETCH;
                        end
                        PC_BRANCH: begin
                            pc_next    = branch_target;
                            state_next = FETCH;
                        end
                        PC_HALT: begin
                            halted_next = 1'b1;
                            state_next  = HALT;
                        end
                        // Unlisted encodings fall back to sequential.
                        default: begin
                            pc_next    = pc_plus4;
                            state_next = FETCH;
                        end
                    endcase
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instruction <= '0;
            instr_count <= '0;
            halted      <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instruction <= instr_next;
            instr_count <= count_next;
            halted      <= halted_next;
        end
    end

endmodule
